// File: rtl/fetch_unit.sv
// Program-counter / next-address stage: selects PC+1 or a LUT jump target each RUN cycle,
// sequences IDLE/RUN/DONE for one program, and counts RUN cycles with saturation.
module fetch_unit #(
   parameter int PC_W       = 10,
   parameter int LUT_IDX_W  = 4,
   parameter int START_ADDR = 0,
   parameter int LAST_ADDR  = 1023,
   parameter int CNT_W      = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic                 Stall,
   input  logic [1:0]           Branch,
   input  logic [LUT_IDX_W-1:0] targetLUT,
   input  logic                 CondFlag,
   input  logic                 lut_we,
   input  logic [LUT_IDX_W-1:0] lut_waddr,
   input  logic [PC_W-1:0]      lut_wdata,
   output logic [PC_W-1:0]      PC,
   output logic                 Running,
   output logic                 Done,
   output logic                 Taken,
   output logic [CNT_W-1:0]     CycleCount
);

   localparam int              LUT_N    = 2 ** LUT_IDX_W;
   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
   localparam logic [PC_W-1:0] LAST_PC  = PC_W'(LAST_ADDR);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic [PC_W-1:0]       pc_q, pc_d;
   logic                  taken_q, taken_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [PC_W-1:0]       lut_q [LUT_N];
   logic [PC_W-1:0]       lut_d [LUT_N];
   logic                  take;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign take = (Branch == 2'b11) |
                 ((Branch == 2'b01) &  CondFlag) |
                 ((Branch == 2'b10) & ~CondFlag);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      taken_d = 1'b0;
      cnt_d   = cnt_q;
      lut_d   = lut_q;
      case (state_q)
         S_RUN: begin
            cnt_d = sat_inc(cnt_q);
            if (!Stall) begin
               // A taken jump wins even at LAST_ADDR; only fall-through ends the program.
               if (take) begin
                  pc_d    = lut_q[targetLUT];
                  taken_d = 1'b1;
               end else if (pc_q == LAST_PC) begin
                  state_d = S_DONE;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
         end
         default: begin
            if (lut_we) begin
               lut_d[lut_waddr] = lut_wdata;
            end
            if (Start) begin
               state_d = S_RUN;
               pc_d    = START_PC;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= START_PC;
         taken_q <= 1'b0;
         cnt_q   <= '0;
         for (int i = 0; i < LUT_N; i++) begin
            lut_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         taken_q <= taken_d;
         cnt_q   <= cnt_d;
         lut_q   <= lut_d;
      end
   end

   assign PC         = pc_q;
   assign Running    = (state_q == S_RUN);
   assign Done       = (state_q == S_DONE);
   assign Taken      = taken_q;
   assign CycleCount = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (LAST_ADDR=8, CNT_W=5): stimulus pushes expected outputs
// into a scoreboard queue; a negedge monitor pops and compares.
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset, Start, Stall, CondFlag, lut_we;
  logic [1:0] Branch;
  logic [3:0] targetLUT, lut_waddr;
  logic [9:0] lut_wdata;
  logic [9:0] PC;
  logic       Running, Done, Taken;
  logic [4:0] CycleCount;

  typedef struct {
    int         cyc;
    string      name;
    logic [9:0] pc;
    logic       run;
    logic       done;
    logic       taken;
    logic [4:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic finished = 1'b0;

  fetch_unit #(
    .PC_W(10), .LUT_IDX_W(4), .START_ADDR(0), .LAST_ADDR(8), .CNT_W(5)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Branch(Branch),
    .targetLUT(targetLUT), .CondFlag(CondFlag), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .PC(PC), .Running(Running),
    .Done(Done), .Taken(Taken), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (PC !== mon_e.pc || Running !== mon_e.run || Done !== mon_e.done ||
          Taken !== mon_e.taken || CycleCount !== mon_e.cnt) begin
        errors++;
        $display("FAIL %s: got pc=%0d run=%b done=%b taken=%b cnt=%0d, want pc=%0d run=%b done=%b taken=%b cnt=%0d",
                 mon_e.name, PC, Running, Done, Taken, CycleCount,
                 mon_e.pc, mon_e.run, mon_e.done, mon_e.taken, mon_e.cnt);
      end
    end
  end

  initial begin
    #20000;
    if (!finished) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete, CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic step(input logic st, input logic sl, input logic [1:0] br,
                      input logic [3:0] idx, input logic cf);
    Start = st; Stall = sl; Branch = br; targetLUT = idx; CondFlag = cf;
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic [9:0] pc, input logic run,
                          input logic done, input logic tk, input logic [4:0] cnt);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.pc = pc; e.run = run;
    e.done = done; e.taken = tk; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic check_now(input string nm, input logic [9:0] pc, input logic run,
                           input logic done, input logic tk, input logic [4:0] cnt);
    checks++;
    if (PC !== pc || Running !== run || Done !== done || Taken !== tk || CycleCount !== cnt) begin
      errors++;
      $display("FAIL %s: got pc=%0d run=%b done=%b taken=%b cnt=%0d, want pc=%0d run=%b done=%b taken=%b cnt=%0d",
               nm, PC, Running, Done, Taken, CycleCount, pc, run, done, tk, cnt);
    end
  endtask

  initial begin
    Reset = 1'b1; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    step(0, 0, 2'b00, 4'd0, 0);
    step(0, 0, 2'b00, 4'd0, 0);
    check_now("reset_state", 10'd0, 0, 0, 0, 5'd0);
    push_exp("reset", 10'd0, 0, 0, 0, 5'd0);
    Reset = 1'b0;

    // Straight-line run to LAST_ADDR=8, then DONE with PC holding.
    step(1, 0, 2'b00, 4'd0, 0);
    push_exp("start", 10'd0, 1, 0, 0, 5'd0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 2'b00, 4'd0, 0);
      push_exp("straight", 10'(k), 1, 0, 0, 5'(k));
    end
    step(0, 0, 2'b00, 4'd0, 0);
    push_exp("done_enter", 10'd8, 0, 1, 0, 5'd9);
    step(0, 0, 2'b11, 4'd3, 0);
    push_exp("done_ignores_branch", 10'd8, 0, 1, 0, 5'd9);

    // LUT writes in DONE; write + Start in the same cycle.
    lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'd40;
    step(0, 0, 2'b00, 4'd0, 0);
    push_exp("lut_write_done", 10'd8, 0, 1, 0, 5'd9);
    lut_waddr = 4'd5; lut_wdata = 10'd17;
    step(1, 0, 2'b00, 4'd0, 0);
    push_exp("restart", 10'd0, 1, 0, 0, 5'd0);
    lut_we = 1'b0;
    step(0, 0, 2'b11, 4'd5, 0);
    push_exp("jump_new_entry", 10'd17, 1, 0, 1, 5'd1);
    step(0, 0, 2'b11, 4'd3, 0);
    push_exp("jump_uncond", 10'd40, 1, 0, 1, 5'd2);
    step(0, 0, 2'b00, 4'd3, 0);
    push_exp("taken_clears", 10'd41, 1, 0, 0, 5'd3);

    // Conditional branches.
    step(0, 0, 2'b01, 4'd3, 0);
    push_exp("br01_cond0", 10'd42, 1, 0, 0, 5'd4);
    step(0, 0, 2'b01, 4'd3, 1);
    push_exp("br01_cond1", 10'd40, 1, 0, 1, 5'd5);
    step(0, 0, 2'b10, 4'd3, 1);
    push_exp("br10_cond1", 10'd41, 1, 0, 0, 5'd6);
    step(0, 0, 2'b10, 4'd3, 0);
    push_exp("br10_cond0", 10'd40, 1, 0, 1, 5'd7);
    step(1, 0, 2'b00, 4'd0, 0);
    push_exp("start_in_run", 10'd41, 1, 0, 0, 5'd8);

    // LUT write during RUN is dropped: LUT[7] stays 0.
    lut_we = 1'b1; lut_waddr = 4'd7; lut_wdata = 10'd4;
    step(0, 0, 2'b00, 4'd0, 0);
    push_exp("lut_write_run", 10'd42, 1, 0, 0, 5'd9);
    lut_we = 1'b0;
    step(0, 0, 2'b11, 4'd7, 0);
    push_exp("lut_unchanged", 10'd0, 1, 0, 1, 5'd10);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 2'b00, 4'd0, 0);
      push_exp("to_pc4", 10'(k), 1, 0, 0, 5'(10 + k));
    end

    // Stall holds PC and suppresses a pending jump; counter keeps going.
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 2'b11, 4'd3, 0);
      push_exp("stall", 10'd4, 1, 0, 0, 5'(14 + k));
    end
    for (int k = 5; k <= 8; k++) begin
      step(0, 0, 2'b00, 4'd0, 0);
      push_exp("after_stall", 10'(k), 1, 0, 0, 5'(13 + k));
    end
    step(0, 0, 2'b11, 4'd5, 0);
    push_exp("jump_at_last", 10'd17, 1, 0, 1, 5'd22);

    // Reset mid-run at PC=17 aborts and clears the LUT.
    Reset = 1'b1;
    step(0, 0, 2'b00, 4'd0, 0);
    check_now("reset_mid_run_state", 10'd0, 0, 0, 0, 5'd0);
    push_exp("reset_mid_run", 10'd0, 0, 0, 0, 5'd0);
    Reset = 1'b0;
    step(1, 0, 2'b00, 4'd0, 0);
    push_exp("start_after_reset", 10'd0, 1, 0, 0, 5'd0);
    step(0, 0, 2'b11, 4'd3, 0);
    push_exp("lut_cleared", 10'd0, 1, 0, 1, 5'd1);

    // Counter saturation at 31.
    for (int k = 0; k < 40; k++) step(0, 1, 2'b00, 4'd0, 0);
    push_exp("cnt_saturate", 10'd0, 1, 0, 0, 5'd31);

    step(0, 0, 2'b00, 4'd0, 0);
    step(0, 0, 2'b00, 4'd0, 0);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations never compared", sb_q.size());
    end
    finished = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
